// File: rtl/fractal_sync_pkg.sv
// Shared constants and helpers for the fractal sync remote CAM: level signature
// bases and the signature range for a given id width.
package fractal_sync_pkg;

    localparam int MAX_LVL_WIDTH = 4;

    // Each level's signatures start after all lower levels' signatures.
    localparam int unsigned LVL_SIG_BASE [2**MAX_LVL_WIDTH] = '{
        0, 1, 3, 7, 15, 31, 63, 127,
        255, 511, 1023, 2047, 4095, 8191, 16383, 32767
    };

    function automatic int unsigned sig_max(input int unsigned id_width);
        return 4 * (2 ** (id_width + 2) - 1) / 6 - 1;
    endfunction

endpackage

// File: rtl/fractal_sync_cam_line.sv
// One CAM line: signature, per-port arrival mask and age counter, with match
// compare against every port and an expiry flag once the age reaches TIMEOUT.
module fractal_sync_cam_line
    import fractal_sync_pkg::*;
#(
    parameter int N_PORTS   = 2,
    parameter int SIG_WIDTH = 2,
    parameter int AGE_WIDTH = 8,
    parameter int TIMEOUT   = 200
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [N_PORTS-1:0][SIG_WIDTH-1:0]  sig_i,
    input  logic [N_PORTS-1:0]                 arrive_i,
    input  logic                               clear_i,
    input  logic                               alloc_i,
    input  logic [SIG_WIDTH-1:0]               alloc_sig_i,
    input  logic [N_PORTS-1:0]                 alloc_mask_i,
    output logic                               valid_o,
    output logic [SIG_WIDTH-1:0]               sig_o,
    output logic [N_PORTS-1:0]                 mask_o,
    output logic [N_PORTS-1:0]                 match_o,
    output logic                               expired_o
);

    typedef struct packed {
        logic                 valid;
        logic [SIG_WIDTH-1:0] sig;
        logic [N_PORTS-1:0]   mask;
        logic [AGE_WIDTH-1:0] age;
    } line_t;

    // With a timeout the age parks at TIMEOUT so a deferred eviction still sees it.
    localparam logic [AGE_WIDTH-1:0] AGE_CAP =
        (TIMEOUT != 0) ? AGE_WIDTH'(TIMEOUT) : {AGE_WIDTH{1'b1}};

    line_t line_q;

    function automatic logic [AGE_WIDTH-1:0] age_sat_inc(input logic [AGE_WIDTH-1:0] age);
        return (age == AGE_CAP) ? age : age + AGE_WIDTH'(1);
    endfunction

    always_ff @(posedge clk_i) begin
        if (rst_i)        line_q.valid <= 1'b0;
        else if (alloc_i) line_q.valid <= 1'b1;
        else if (clear_i) line_q.valid <= 1'b0;

        if (alloc_i) begin
            line_q.sig  <= alloc_sig_i;
            line_q.mask <= alloc_mask_i;
            line_q.age  <= '0;
        end else if (|arrive_i) begin
            line_q.mask <= line_q.mask | arrive_i;
            line_q.age  <= '0;
        end else begin
            line_q.age  <= age_sat_inc(line_q.age);
        end
    end

    always_comb begin
        for (int p = 0; p < N_PORTS; p++) begin
            match_o[p] = line_q.valid && (sig_i[p] == line_q.sig);
        end
    end

    assign valid_o   = line_q.valid;
    assign sig_o     = line_q.sig;
    assign mask_o    = line_q.mask;
    assign expired_o = (TIMEOUT != 0) && line_q.valid && (line_q.age == AGE_CAP);

endmodule

// File: rtl/fractal_sync_np_remote_cam.sv
// N-port barrier collector: maps (level, id) to a signature, tracks partial
// arrivals in CAM lines, applies backpressure when full and evicts stale lines.
module fractal_sync_np_remote_cam
    import fractal_sync_pkg::*;
#(
    parameter int N_PORTS     = 2,
    parameter int LEVEL_WIDTH = 1,
    parameter int ID_WIDTH    = 1,
    parameter int N_LINES     = 4,
    parameter int AGE_WIDTH   = 8,
    parameter int TIMEOUT     = 200,
    parameter int SIG_WIDTH   = $clog2(4 * (2 ** (ID_WIDTH + 2) - 1) / 6)
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [N_PORTS-1:0]                    req_i,
    input  logic [N_PORTS-1:0][LEVEL_WIDTH-1:0]   level_i,
    input  logic [N_PORTS-1:0][ID_WIDTH-1:0]      id_i,
    output logic [N_PORTS-1:0]                    ready_o,
    output logic [N_PORTS-1:0]                    present_o,
    output logic [N_PORTS-1:0]                    err_o,
    output logic                                  bypass_o,
    output logic                                  full_o,
    output logic                                  timeout_o,
    output logic [SIG_WIDTH-1:0]                  timeout_sig_o
);

    localparam int unsigned MAX_SIG = sig_max(ID_WIDTH);

    logic [N_PORTS-1:0][SIG_WIDTH-1:0] sig;
    logic [N_PORTS-1:0] sig_ok, hit, dup, new_req, grant, acc, present_d, err_d;
    logic bypass_d, alloc_found, evict_found;
    logic [N_LINES-1:0][N_PORTS-1:0] line_match, line_mask, arrive, alloc_mask;
    logic [N_LINES-1:0][SIG_WIDTH-1:0] line_sig, alloc_sig;
    logic [N_LINES-1:0] line_valid, line_expired, alloc_en, complete, evict, clear, valid_next;
    logic [SIG_WIDTH-1:0] evict_sig;

    // The range check uses the unwrapped sum so high levels cannot alias into range.
    always_comb begin
        for (int p = 0; p < N_PORTS; p++) begin
            sig_ok[p] = (LVL_SIG_BASE[MAX_LVL_WIDTH'(level_i[p])] + 32'(id_i[p])) <= MAX_SIG;
            sig[p]    = SIG_WIDTH'(LVL_SIG_BASE[MAX_LVL_WIDTH'(level_i[p])] + 32'(id_i[p]));
        end
    end

    always_comb begin
        hit = '0;
        dup = '0;
        for (int p = 0; p < N_PORTS; p++) begin
            for (int l = 0; l < N_LINES; l++) begin
                hit[p] = hit[p] | (req_i[p] & sig_ok[p] & line_match[l][p]);
                dup[p] = dup[p] | (req_i[p] & sig_ok[p] & line_match[l][p] & line_mask[l][p]);
            end
        end

        bypass_d = (&req_i) & (&sig_ok) & ~hit[0];
        for (int p = 1; p < N_PORTS; p++) begin
            if (sig[p] != sig[0]) bypass_d = 1'b0;
        end

        // Misses join a line opened earlier this cycle for the same sig, else take the lowest free one.
        new_req    = req_i & sig_ok & ~hit & {N_PORTS{~bypass_d}};
        grant      = '0;
        alloc_en   = '0;
        alloc_sig  = '0;
        alloc_mask = '0;
        for (int p = 0; p < N_PORTS; p++) begin
            alloc_found = 1'b0;
            if (new_req[p]) begin
                for (int l = 0; l < N_LINES; l++) begin
                    if (!alloc_found && alloc_en[l] && alloc_sig[l] == sig[p]) begin
                        alloc_found      = 1'b1;
                        alloc_mask[l][p] = 1'b1;
                    end
                end
                for (int l = 0; l < N_LINES; l++) begin
                    if (!alloc_found && !line_valid[l] && !alloc_en[l]) begin
                        alloc_found      = 1'b1;
                        alloc_en[l]      = 1'b1;
                        alloc_sig[l]     = sig[p];
                        alloc_mask[l][p] = 1'b1;
                    end
                end
            end
            grant[p] = alloc_found;
        end

        ready_o = ~(new_req & ~grant);
        acc     = req_i & ready_o;
        err_d   = acc & (~sig_ok | dup);

        present_d = '0;
        for (int l = 0; l < N_LINES; l++) begin
            arrive[l]   = acc & sig_ok & line_match[l];
            complete[l] = line_valid[l] & (|arrive[l]) & (&(line_mask[l] | arrive[l]));
            present_d   = present_d | ({N_PORTS{complete[l]}} & arrive[l] & ~line_mask[l]);
        end

        // An arrival on an expiring line keeps it alive; only one eviction per cycle.
        evict       = '0;
        evict_sig   = '0;
        evict_found = 1'b0;
        for (int l = 0; l < N_LINES; l++) begin
            if (!evict_found && line_expired[l] && !(|arrive[l])) begin
                evict_found = 1'b1;
                evict[l]    = 1'b1;
                evict_sig   = line_sig[l];
            end
        end

        clear      = complete | evict;
        valid_next = alloc_en | (line_valid & ~clear);
    end

    for (genvar l = 0; l < N_LINES; l++) begin : g_line
        fractal_sync_cam_line #(
            .N_PORTS   (N_PORTS),
            .SIG_WIDTH (SIG_WIDTH),
            .AGE_WIDTH (AGE_WIDTH),
            .TIMEOUT   (TIMEOUT)
        ) u_line (
            .clk_i        (clk_i),
            .rst_i        (rst_i),
            .sig_i        (sig),
            .arrive_i     (arrive[l]),
            .clear_i      (clear[l]),
            .alloc_i      (alloc_en[l]),
            .alloc_sig_i  (alloc_sig[l]),
            .alloc_mask_i (alloc_mask[l]),
            .valid_o      (line_valid[l]),
            .sig_o        (line_sig[l]),
            .mask_o       (line_mask[l]),
            .match_o      (line_match[l]),
            .expired_o    (line_expired[l])
        );
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            present_o     <= '0;
            err_o         <= '0;
            bypass_o      <= 1'b0;
            full_o        <= 1'b0;
            timeout_o     <= 1'b0;
            timeout_sig_o <= '0;
        end else begin
            present_o <= present_d;
            err_o     <= err_d;
            bypass_o  <= bypass_d;
            full_o    <= &valid_next;
            timeout_o <= |evict;
            if (|evict) timeout_sig_o <= evict_sig;
        end
    end

endmodule

// File: tb/tb_fractal_sync_np_remote_cam.sv
// Scoreboard bench: stimulus queues expected pulse events, a negedge monitor
// pops and compares them whenever the DUT raises a pulse output.
module tb_fractal_sync_np_remote_cam;

    localparam int NP = 4;
    localparam int LW = 2;
    localparam int IW = 2;
    localparam int NL = 2;
    localparam int AW = 8;
    localparam int TO = 5;
    localparam int SW = 4;

    logic clk = 1'b0;
    logic rst;
    logic [NP-1:0]         req;
    logic [NP-1:0][LW-1:0] level;
    logic [NP-1:0][IW-1:0] id;
    logic [NP-1:0]         ready, present, err;
    logic                  bypass, full, tmo;
    logic [SW-1:0]         tsig;

    fractal_sync_np_remote_cam #(
        .N_PORTS(NP), .LEVEL_WIDTH(LW), .ID_WIDTH(IW),
        .N_LINES(NL), .AGE_WIDTH(AW), .TIMEOUT(TO)
    ) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .level_i(level), .id_i(id),
        .ready_o(ready), .present_o(present), .err_o(err), .bypass_o(bypass),
        .full_o(full), .timeout_o(tmo), .timeout_sig_o(tsig)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [3:0] pr;
        logic [3:0] er;
        logic       by;
        logic       tm;
        logic [3:0] ts;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int p, input int l, input int i);
        req[p]   = 1'b1;
        level[p] = LW'(l);
        id[p]    = IW'(i);
    endtask

    // delay counts edges from now: 1 = the acceptance edge itself
    task automatic expect_ev(input logic [3:0] pr, input logic [3:0] er, input logic by,
                             input logic tm, input logic [3:0] ts, input int delay);
        exp_t e;
        e.cyc = cyc + delay;
        e.pr  = pr;
        e.er  = er;
        e.by  = by;
        e.tm  = tm;
        e.ts  = ts;
        sb_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (present != 0 || err != 0 || bypass || tmo) begin
            n_cmp++;
            if (sb_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_pulse cyc=%0d present=%b err=%b bypass=%b timeout=%b",
                         cyc, present, err, bypass, tmo);
            end else begin
                mon_e = sb_q.pop_front();
                if (mon_e.cyc != cyc || mon_e.pr !== present || mon_e.er !== err ||
                    mon_e.by !== bypass || mon_e.tm !== tmo || (mon_e.tm && mon_e.ts !== tsig)) begin
                    n_bad++;
                    $display("FAIL pulse: got cyc=%0d present=%b err=%b bypass=%b timeout=%b tsig=%0d; expected cyc=%0d present=%b err=%b bypass=%b timeout=%b tsig=%0d",
                             cyc, present, err, bypass, tmo, tsig,
                             mon_e.cyc, mon_e.pr, mon_e.er, mon_e.by, mon_e.tm, mon_e.ts);
                end
            end
        end else if (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            n_cmp++;
            n_bad++;
            mon_e = sb_q.pop_front();
            $display("FAIL missing_pulse: got none at cyc=%0d expected present=%b err=%b bypass=%b timeout=%b at cyc=%0d",
                     cyc, mon_e.pr, mon_e.er, mon_e.by, mon_e.tm, mon_e.cyc);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst   = 1'b1;
        req   = '0;
        level = '0;
        id    = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("reset_present", present, 0);
        chk("reset_err", err, 0);
        chk("reset_bypass", bypass, 0);
        chk("reset_timeout", tmo, 0);
        chk("reset_full", full, 0);
        chk("reset_tsig", tsig, 0);
        chk("reset_ready", ready, 4'hF);

        // Bypass: all ports level 1 id 0 (sig 1)
        for (int p = 0; p < NP; p++) set_port(p, 1, 0);
        #1 chk("bypass_ready", ready, 4'hF);
        expect_ev(4'b0000, 4'b0000, 1'b1, 1'b0, 4'd0, 1);
        tick();
        req = '0;
        chk("bypass_full", full, 0);

        // Split arrival on sig 5 (level 2 id 2): ports 0,1 then ports 2,3 three cycles later
        set_port(0, 2, 2);
        set_port(1, 2, 2);
        #1 chk("split_ready_a", ready, 4'hF);
        tick();
        req = '0;
        tick();
        tick();
        set_port(2, 2, 2);
        set_port(3, 2, 2);
        #1 chk("split_ready_b", ready, 4'hF);
        expect_ev(4'b1100, 4'b0000, 1'b0, 1'b0, 4'd0, 1);
        tick();
        req = '0;
        chk("split_freed_full", full, 0);

        // Full: sigs 0,1,2 on ports 0,1,2 with two lines
        set_port(0, 0, 0);
        set_port(1, 0, 1);
        set_port(2, 0, 2);
        #1 chk("full_ready_a", ready, 4'b1011);
        tick();
        req[0] = 1'b0;
        req[1] = 1'b0;
        chk("full_set", full, 1);
        #1 chk("full_ready_hold", ready, 4'b1011);
        tick();
        // Complete sig 0 with ports 1..3; port 0 asks for sig 2 in the freeing cycle
        req = '0;
        set_port(0, 0, 2);
        set_port(1, 0, 0);
        set_port(2, 0, 0);
        set_port(3, 0, 0);
        #1 chk("free_cycle_ready", ready, 4'b1110);
        expect_ev(4'b1110, 4'b0000, 1'b0, 1'b0, 4'd0, 1);
        tick();
        chk("after_free_full", full, 0);
        req[1] = 1'b0;
        req[3] = 1'b0;
        set_port(2, 0, 2);
        #1 chk("after_free_ready", ready, 4'hF);
        tick();
        req = '0;
        chk("realloc_full", full, 1);

        // Duplicate arrival of port 1 on its pending sig 1
        set_port(1, 0, 1);
        #1 chk("dup_ready", ready, 4'hF);
        expect_ev(4'b0000, 4'b0010, 1'b0, 1'b0, 4'd0, 1);
        tick();
        req = '0;

        // Out-of-range signature: level 3 id 3 -> 10 > 9
        set_port(3, 3, 3);
        #1 chk("badsig_ready", ready, 4'hF);
        expect_ev(4'b0000, 4'b1000, 1'b0, 1'b0, 4'd0, 1);
        tick();
        req = '0;
        chk("badsig_full", full, 1);

        // Reset with two lines pending
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_full", full, 0);
        chk("midrst_present", present, 0);
        chk("midrst_err", err, 0);
        chk("midrst_timeout", tmo, 0);
        chk("midrst_tsig", tsig, 0);

        // Lone arrival on sig 3 (level 2 id 0): fresh line, then timeout
        set_port(0, 2, 0);
        #1 chk("lone_ready", ready, 4'hF);
        expect_ev(4'b0000, 4'b0000, 1'b0, 1'b1, 4'd3, 7);
        tick();
        req = '0;
        chk("lone_full", full, 0);
        repeat (8) tick();
        chk("lone_after_full", full, 0);
        chk("lone_tsig_held", tsig, 3);

        // Two lines expiring together: lower line first, the other one cycle later
        set_port(0, 2, 0);
        set_port(1, 2, 1);
        #1 chk("dual_ready", ready, 4'hF);
        expect_ev(4'b0000, 4'b0000, 1'b0, 1'b1, 4'd3, 7);
        expect_ev(4'b0000, 4'b0000, 1'b0, 1'b1, 4'd4, 8);
        tick();
        req = '0;
        chk("dual_full", full, 1);
        repeat (9) tick();
        chk("dual_after_full", full, 0);
        chk("dual_tsig_held", tsig, 4);

        repeat (3) tick();
        while (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL leftover_event: got nothing expected present=%b err=%b bypass=%b timeout=%b at cyc=%0d",
                     mon_e.pr, mon_e.er, mon_e.by, mon_e.tm, mon_e.cyc);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
